// File: rtl/mc_main_control_if.sv
// Memory handshake between the main control FSM and memory.
// master: control drives mem_read/mem_write/iord, samples mem_ready.
interface mc_main_control_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: decodes opcode/funct, drives strobes.
// Ports: clk, rst (sync high), opcode, funct, mem (handshake), strobes.
module mc_main_control #(
  parameter int RA_REG = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  mc_main_control_if.master mem,
  output logic       pc_write,
  output logic       pc_write_eq,
  output logic       pc_write_ne,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_op,
  output logic       illegal_op
);

  // reg_dst=2'b10 selects RA_REG in the datapath; it must be a valid index.
  if (RA_REG < 0 || RA_REG > 31) begin : g_bad_ra
    $error("RA_REG must be a register index 0..31");
  end

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_SLTU = 6'b001011;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_RTEXEC, S_RTWB,
    S_IEXEC, S_IWB, S_BEQ, S_BNE,
    S_JUMP, S_JAL, S_JR
  } state_t;

  state_t state;
  state_t nxt;

  logic is_mem;
  logic is_rt;
  logic is_jr;
  logic is_ialu;
  logic is_legal;

  always_comb begin
    is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
    is_jr   = (opcode == OP_RT) && (funct == FN_JR);
    is_rt   = (opcode == OP_RT) && (funct != FN_JR);
    is_ialu = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
              (opcode == OP_SLTU) || (opcode == OP_ANDI) ||
              (opcode == OP_ORI)  || (opcode == OP_XORI) ||
              (opcode == OP_LUI);
    is_legal = is_mem || is_jr || is_rt || is_ialu ||
               (opcode == OP_BEQ) || (opcode == OP_BNE) ||
               (opcode == OP_J)   || (opcode == OP_JAL);
  end

  // ALU setup shared by IEXEC and IWB so the result stays stable.
  logic [3:0] i_op;
  logic [2:0] i_srcb;

  always_comb begin
    i_op   = 4'b0000;
    i_srcb = 3'b010;
    case (opcode)
      OP_SLTI: i_op = 4'b0100;
      OP_SLTU: i_op = 4'b1001;
      OP_ANDI: begin i_op = 4'b0101; i_srcb = 3'b100; end
      OP_ORI:  begin i_op = 4'b0110; i_srcb = 3'b100; end
      OP_XORI: begin i_op = 4'b0111; i_srcb = 3'b100; end
      OP_LUI:  begin i_op = 4'b0011; i_srcb = 3'b100; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_FETCH:  if (mem.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:              nxt = S_MEMADR;
          is_jr:               nxt = S_JR;
          is_rt:               nxt = S_RTEXEC;
          is_ialu:             nxt = S_IEXEC;
          (opcode == OP_BEQ):  nxt = S_BEQ;
          (opcode == OP_BNE):  nxt = S_BNE;
          (opcode == OP_J):    nxt = S_JUMP;
          (opcode == OP_JAL):  nxt = S_JAL;
          default:             nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem.mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem.mem_ready) nxt = S_FETCH;
      S_RTEXEC: nxt = S_RTWB;
      S_IEXEC:  nxt = S_IWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // Outputs are held at zero while rst is high, whatever the state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_eq   = 1'b0;
    pc_write_ne   = 1'b0;
    mem.iord      = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 3'b000;
    pc_source     = 2'b00;
    alu_op        = 4'b0000;
    illegal_op    = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem.mem_read = 1'b1;
          alu_src_b    = 3'b001;
          ir_write     = mem.mem_ready;
          pc_write     = mem.mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 3'b011;
          illegal_op = !is_legal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 3'b010;
        end
        S_MEMRD: begin
          mem.mem_read = 1'b1;
          mem.iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem.mem_write = 1'b1;
          mem.iord      = 1'b1;
        end
        S_RTEXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 4'b0010;
        end
        S_RTWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = i_srcb;
          alu_op    = i_op;
        end
        S_IWB: begin
          reg_write = 1'b1;
          alu_src_b = i_srcb;
          alu_op    = i_op;
        end
        S_BEQ: begin
          alu_src_a   = 1'b1;
          alu_op      = 4'b0001;
          pc_source   = 2'b01;
          pc_write_eq = 1'b1;
        end
        S_BNE: begin
          alu_src_a   = 1'b1;
          alu_op      = 4'b0001;
          pc_source   = 2'b01;
          pc_write_ne = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_JAL: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          reg_write = 1'b1;
          reg_dst   = 2'b10;
        end
        S_JR: begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: directed per-cycle vectors.
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_mc_main_control;

  typedef struct packed {
    logic       pcw;
    logic       eq;
    logic       ne;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rw;
    logic [1:0] rd;
    logic       sa;
    logic [2:0] sb;
    logic [1:0] ps;
    logic [3:0] op;
    logic       ill;
  } ctl_t;

  typedef struct {
    ctl_t  e;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       pc_write, pc_write_eq, pc_write_ne;
  logic       ir_write, mem_to_reg, reg_write;
  logic [1:0] reg_dst;
  logic       alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_op;
  logic       illegal_op;

  mc_main_control_if m ();

  mc_main_control #(.RA_REG(31)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .mem         (m.master),
    .pc_write    (pc_write),
    .pc_write_eq (pc_write_eq),
    .pc_write_ne (pc_write_ne),
    .ir_write    (ir_write),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_source   (pc_source),
    .alu_op      (alu_op),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  item_t q[$];
  int checks   = 0;
  int failures = 0;

  function automatic ctl_t v(
    input logic pcw, eq, ne, iord, mr, mw, irw, m2r, rw,
    input logic [1:0] rd, input logic sa, input logic [2:0] sb,
    input logic [1:0] ps, input logic [3:0] op, input logic ill);
    ctl_t c;
    c = {pcw, eq, ne, iord, mr, mw, irw, m2r, rw, rd, sa, sb, ps, op, ill};
    return c;
  endfunction

  ctl_t act;
  always_comb begin
    act = {pc_write, pc_write_eq, pc_write_ne, m.iord, m.mem_read,
           m.mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
           alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (act !== it.e) begin
        failures++;
        $display("FAIL %s: got %b want %b", it.tag, act, it.e);
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] op,
                      input logic [5:0] fn, input logic rdy,
                      input ctl_t e, input string tag);
    item_t it;
    rst         = r;
    opcode      = op;
    funct       = fn;
    m.mem_ready = rdy;
    it.e   = e;
    it.tag = tag;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  ctl_t ZERO, F_RDY, F_STL, DEC, DEC_ILL, MADR, MRD, MWB, MWR;
  ctl_t RTE, RTW, JRS, BEQS, BNES, JMP, JALS;
  ctl_t IE_ORI, IW_ORI, IE_ADDI, IW_ADDI, IE_LUI, IW_LUI;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] JRF = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] LUI = 6'b001111;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    ZERO    = '0;
    F_RDY   = v(1,0,0,0,1,0,1,0,0,2'b00,0,3'b001,2'b00,4'b0000,0);
    F_STL   = v(0,0,0,0,1,0,0,0,0,2'b00,0,3'b001,2'b00,4'b0000,0);
    DEC     = v(0,0,0,0,0,0,0,0,0,2'b00,0,3'b011,2'b00,4'b0000,0);
    DEC_ILL = v(0,0,0,0,0,0,0,0,0,2'b00,0,3'b011,2'b00,4'b0000,1);
    MADR    = v(0,0,0,0,0,0,0,0,0,2'b00,1,3'b010,2'b00,4'b0000,0);
    MRD     = v(0,0,0,1,1,0,0,0,0,2'b00,0,3'b000,2'b00,4'b0000,0);
    MWB     = v(0,0,0,0,0,0,0,1,1,2'b00,0,3'b000,2'b00,4'b0000,0);
    MWR     = v(0,0,0,1,0,1,0,0,0,2'b00,0,3'b000,2'b00,4'b0000,0);
    RTE     = v(0,0,0,0,0,0,0,0,0,2'b00,1,3'b000,2'b00,4'b0010,0);
    RTW     = v(0,0,0,0,0,0,0,0,1,2'b01,0,3'b000,2'b00,4'b0000,0);
    JRS     = v(1,0,0,0,0,0,0,0,0,2'b00,0,3'b000,2'b11,4'b0000,0);
    BEQS    = v(0,1,0,0,0,0,0,0,0,2'b00,1,3'b000,2'b01,4'b0001,0);
    BNES    = v(0,0,1,0,0,0,0,0,0,2'b00,1,3'b000,2'b01,4'b0001,0);
    JMP     = v(1,0,0,0,0,0,0,0,0,2'b00,0,3'b000,2'b10,4'b0000,0);
    JALS    = v(1,0,0,0,0,0,0,0,1,2'b10,0,3'b000,2'b10,4'b0000,0);
    IE_ORI  = v(0,0,0,0,0,0,0,0,0,2'b00,1,3'b100,2'b00,4'b0110,0);
    IW_ORI  = v(0,0,0,0,0,0,0,0,1,2'b00,0,3'b100,2'b00,4'b0110,0);
    IE_ADDI = v(0,0,0,0,0,0,0,0,0,2'b00,1,3'b010,2'b00,4'b0000,0);
    IW_ADDI = v(0,0,0,0,0,0,0,0,1,2'b00,0,3'b010,2'b00,4'b0000,0);
    IE_LUI  = v(0,0,0,0,0,0,0,0,0,2'b00,1,3'b100,2'b00,4'b0011,0);
    IW_LUI  = v(0,0,0,0,0,0,0,0,1,2'b00,0,3'b100,2'b00,4'b0011,0);

    rst = 1'b1; opcode = LW; funct = '0; m.mem_ready = 1'b1;
    @(posedge clk); #1;

    step(1, LW, 6'd0, 1, ZERO, "reset0");
    step(1, BAD, 6'd0, 1, ZERO, "reset1");

    // lw, no stalls: 5 cycles
    step(0, LW, 6'd0, 1, F_RDY, "lw_fetch");
    step(0, LW, 6'd0, 1, DEC,   "lw_decode");
    step(0, LW, 6'd0, 1, MADR,  "lw_memadr");
    step(0, LW, 6'd0, 1, MRD,   "lw_memrd");
    step(0, LW, 6'd0, 1, MWB,   "lw_memwb");

    // sw with 3 stall cycles in MEMWR: 7 cycles
    step(0, SW, 6'd0, 1, F_RDY, "sw_fetch");
    step(0, SW, 6'd0, 1, DEC,   "sw_decode");
    step(0, SW, 6'd0, 1, MADR,  "sw_memadr");
    step(0, SW, 6'd0, 0, MWR,   "sw_stall1");
    step(0, SW, 6'd0, 0, MWR,   "sw_stall2");
    step(0, SW, 6'd0, 0, MWR,   "sw_stall3");
    step(0, SW, 6'd0, 1, MWR,   "sw_memwr");

    // R-type add, with one fetch stall first
    step(0, RT, ADD, 0, F_STL, "add_fstall");
    step(0, RT, ADD, 1, F_RDY, "add_fetch");
    step(0, RT, ADD, 1, DEC,   "add_decode");
    step(0, RT, ADD, 0, RTE,   "add_rtexec");
    step(0, RT, ADD, 0, RTW,   "add_rtwb");

    // jr
    step(0, RT, JRF, 1, F_RDY, "jr_fetch");
    step(0, RT, JRF, 1, DEC,   "jr_decode");
    step(0, RT, JRF, 1, JRS,   "jr_exec");

    // I-type ALU
    step(0, ORI, 6'd0, 1, F_RDY,  "ori_fetch");
    step(0, ORI, 6'd0, 1, DEC,    "ori_decode");
    step(0, ORI, 6'd0, 1, IE_ORI, "ori_iexec");
    step(0, ORI, 6'd0, 1, IW_ORI, "ori_iwb");
    step(0, ADI, 6'd0, 1, F_RDY,   "addi_fetch");
    step(0, ADI, 6'd0, 1, DEC,     "addi_decode");
    step(0, ADI, 6'd0, 1, IE_ADDI, "addi_iexec");
    step(0, ADI, 6'd0, 1, IW_ADDI, "addi_iwb");
    step(0, LUI, 6'd0, 1, F_RDY,  "lui_fetch");
    step(0, LUI, 6'd0, 1, DEC,    "lui_decode");
    step(0, LUI, 6'd0, 1, IE_LUI, "lui_iexec");
    step(0, LUI, 6'd0, 1, IW_LUI, "lui_iwb");

    // branches and jumps
    step(0, BEQ, 6'd0, 1, F_RDY, "beq_fetch");
    step(0, BEQ, 6'd0, 1, DEC,   "beq_decode");
    step(0, BEQ, 6'd0, 1, BEQS,  "beq_exec");
    step(0, BNE, 6'd0, 1, F_RDY, "bne_fetch");
    step(0, BNE, 6'd0, 1, DEC,   "bne_decode");
    step(0, BNE, 6'd0, 1, BNES,  "bne_exec");
    step(0, J,   6'd0, 1, F_RDY, "j_fetch");
    step(0, J,   6'd0, 1, DEC,   "j_decode");
    step(0, J,   6'd0, 1, JMP,   "j_exec");
    step(0, JAL, 6'd0, 1, F_RDY, "jal_fetch");
    step(0, JAL, 6'd0, 1, DEC,   "jal_decode");
    step(0, JAL, 6'd0, 1, JALS,  "jal_exec");

    // illegal opcode: one-cycle pulse, then straight back to FETCH
    step(0, BAD, 6'd0, 1, F_RDY,   "ill_fetch");
    step(0, BAD, 6'd0, 1, DEC_ILL, "ill_decode");
    step(0, BAD, 6'd0, 0, F_STL,   "ill_refetch");

    // reset during MEMRD stall aborts the load
    step(0, LW, 6'd0, 1, F_RDY, "rlw_fetch");
    step(0, LW, 6'd0, 1, DEC,   "rlw_decode");
    step(0, LW, 6'd0, 1, MADR,  "rlw_memadr");
    step(0, LW, 6'd0, 0, MRD,   "rlw_stall");
    step(1, LW, 6'd0, 0, ZERO,  "rlw_reset");
    step(0, LW, 6'd0, 0, F_STL, "rlw_refetch");
    step(0, LW, 6'd0, 1, F_RDY, "rlw_fetch2");

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
